// File: rtl/jtag_uart_sys_mem_loader.sv
// Packs an 8-bit valid/ready byte stream little-endian into 32-bit words and
// writes them into a byte-enabled single-port RAM at a word-addressed window.
module jtag_uart_sys_mem_loader #(
    parameter int ADDR_W = 11,
    parameter int CNT_W  = 13
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [CNT_W-1:0]  byte_count,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic [ADDR_W-1:0] mem_address,
    output logic [3:0]        mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [31:0]       mem_writedata,
    output logic              busy,
    output logic              done,
    output logic [15:0]       checksum,
    output logic              wrapped
);

    typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;

    state_t             state, state_n;
    logic [1:0]         lane;
    logic [CNT_W-1:0]   remaining;
    logic [31:0]        word, word_n;
    logic [3:0]         be, be_n;
    logic               accept;

    always_comb begin
        state_n = state;
        accept  = 1'b0;
        word_n  = word;
        be_n    = be;
        case (state)
            IDLE: begin
                if (start)
                    state_n = (byte_count == '0) ? DONE : COLLECT;
            end
            COLLECT: begin
                accept = in_valid & in_ready;
                if (accept) begin
                    word_n[{lane, 3'b000} +: 8] = in_data;
                    be_n[lane]                  = 1'b1;
                    // lane 3 filled means the word is full
                    if (lane == 2'd3 || remaining == CNT_W'(1))
                        state_n = WRITE;
                end
            end
            WRITE:   state_n = (remaining == '0) ? DONE : COLLECT;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            lane           <= '0;
            remaining      <= '0;
            word           <= '0;
            be             <= '0;
            in_ready       <= 1'b0;
            mem_address    <= '0;
            mem_byteenable <= '0;
            mem_chipselect <= 1'b0;
            mem_write      <= 1'b0;
            mem_writedata  <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            checksum       <= '0;
            wrapped        <= 1'b0;
        end else begin
            state <= state_n;
            // Outputs are registered from the next state so they line up with it
            in_ready       <= (state_n == COLLECT);
            busy           <= (state_n != IDLE);
            done           <= (state_n == DONE);
            mem_chipselect <= (state_n == WRITE);
            mem_write      <= (state_n == WRITE);
            mem_byteenable <= (state_n == WRITE) ? be_n : 4'b0;
            if (state_n == WRITE)
                mem_writedata <= word_n;

            case (state)
                IDLE: begin
                    if (start) begin
                        mem_address <= start_addr;
                        remaining   <= byte_count;
                        checksum    <= '0;
                        wrapped     <= 1'b0;
                        lane        <= '0;
                        word        <= '0;
                        be          <= '0;
                    end
                end
                COLLECT: begin
                    if (accept) begin
                        word      <= word_n;
                        be        <= be_n;
                        checksum  <= checksum + 16'(in_data);
                        remaining <= remaining - CNT_W'(1);
                        lane      <= lane + 2'd1;
                    end
                end
                WRITE: begin
                    mem_address <= mem_address + ADDR_W'(1);
                    if (&mem_address)
                        wrapped <= 1'b1;
                    word <= '0;
                    be   <= '0;
                    lane <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_jtag_uart_sys_mem_loader.sv
// Bench for jtag_uart_sys_mem_loader: directed table, abort sequence and
// randomized loads checked against a word-level reference model.
module tb_jtag_uart_sys_mem_loader;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [10:0] start_addr = '0;
    logic [12:0] byte_count = '0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_ready;
    logic [10:0] mem_address;
    logic [3:0]  mem_byteenable;
    logic        mem_chipselect;
    logic        mem_write;
    logic [31:0] mem_writedata;
    logic        busy;
    logic        done;
    logic [15:0] checksum;
    logic        wrapped;

    jtag_uart_sys_mem_loader dut (
        .clk(clk), .reset_n(reset_n), .start(start), .start_addr(start_addr),
        .byte_count(byte_count), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .busy(busy), .done(done),
        .checksum(checksum), .wrapped(wrapped)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [10:0] a;
        logic [31:0] d;
        logic [3:0]  be;
        int          c;
    } wr_t;

    wr_t  obs[$];
    int   acc_cyc[$];
    int   done_cyc[$];
    int   viol = 0;
    int   errors = 0;
    int   checks = 0;
    int   st_cyc;
    logic [7:0] bytes [16];

    // Observe the RAM port, the byte handshake and done pulses mid-cycle
    always @(negedge clk) begin
        if (mem_chipselect && mem_write)
            obs.push_back('{mem_address, mem_writedata, mem_byteenable, cyc});
        if ((mem_chipselect != mem_write) || (!mem_write && mem_byteenable != 4'b0))
            viol++;
        if (in_valid && in_ready)
            acc_cyc.push_back(cyc);
        if (done)
            done_cyc.push_back(cyc);
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic clear_obs();
        obs.delete();
        acc_cyc.delete();
        done_cyc.delete();
        viol = 0;
    endtask

    // Runs one load; inject>=0 fires a stray start once that many bytes are in
    task automatic run_load(input logic [10:0] sa, input int cnt, input int gap, input int inject);
        int  i;
        int  n;
        bit  acc;
        bit  injected;
        clear_obs();
        @(posedge clk); #1;
        start = 1'b1; start_addr = sa; byte_count = 13'(cnt);
        @(negedge clk); st_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0; start_addr = 11'($urandom); byte_count = 13'($urandom);
        i = 0; n = 0; injected = 0;
        while (i < cnt && n < 400) begin
            in_valid = ($urandom_range(99) >= gap);
            in_data  = bytes[i];
            if (i == inject && !injected) begin
                start = 1'b1; start_addr = 11'h555; byte_count = 13'd1; injected = 1;
            end
            @(negedge clk); acc = in_valid && in_ready;
            @(posedge clk); #1;
            start = 1'b0;
            if (acc) i++;
            n++;
        end
        in_valid = 1'b0;
        chk("accept_timeout", i, cnt);
        n = 0;
        while (done_cyc.size() == 0 && n < 50) begin
            @(posedge clk); n++;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("done_pulses", done_cyc.size(), 1);
        chk("idle_busy", busy, 0);
        chk("idle_ready", in_ready, 0);
    endtask

    // Word-level reference: expected writes, checksum, wrap and latencies
    task automatic check_model(input logic [10:0] sa, input int cnt);
        int          nw;
        int          sum;
        int          last;
        logic [31:0] d;
        logic [3:0]  be;
        nw = (cnt + 3) / 4;
        sum = 0;
        chk("n_writes", obs.size(), nw);
        chk("accept_count", acc_cyc.size(), cnt);
        for (int w = 0; w < nw; w++) begin
            d = '0; be = '0;
            for (int k = 0; k < 4; k++)
                if (4 * w + k < cnt) begin
                    d  = d | (32'(bytes[4 * w + k]) << (8 * k));
                    be[k] = 1'b1;
                end
            if (w < obs.size()) begin
                chk("wr_addr", obs[w].a, (int'(sa) + w) % 2048);
                chk("wr_data", obs[w].d, d);
                chk("wr_be", obs[w].be, be);
                last = (4 * w + 3 < cnt) ? 4 * w + 3 : cnt - 1;
                if (last < acc_cyc.size())
                    chk("wr_latency", obs[w].c, acc_cyc[last] + 1);
            end
        end
        for (int i = 0; i < cnt; i++) sum += bytes[i];
        chk("checksum", checksum, sum % 65536);
        chk("wrapped", wrapped, (nw > 0 && int'(sa) + nw >= 2048) ? 1 : 0);
        if (done_cyc.size() > 0)
            chk("done_latency", done_cyc[0],
                (nw == 0) ? st_cyc + 1 : ((obs.size() > 0) ? obs[obs.size() - 1].c + 1 : -1));
        chk("strobe_viol", viol, 0);
    endtask

    typedef struct {
        logic [10:0] sa;
        int          cnt;
        int          gap;
        int          inject;
        int          nw;
        logic [10:0] a0;
        logic [31:0] d0;
        logic [3:0]  b0;
        logic [10:0] al;
        logic [31:0] dl;
        logic [3:0]  bl;
        logic [15:0] cks;
        logic        wrap;
    } vec_t;

    vec_t tv [7];

    initial begin
        tv[0] = '{11'h010, 8, 0, -1, 2, 11'h010, 32'h44332211, 4'hF, 11'h011, 32'h88776655, 4'hF, 16'h0264, 1'b0};
        tv[1] = '{11'h010, 6, 0, -1, 2, 11'h010, 32'h44332211, 4'hF, 11'h011, 32'h00006655, 4'h3, 16'h0165, 1'b0};
        tv[2] = '{11'h123, 0, 0, -1, 0, 11'h000, 32'h0, 4'h0, 11'h000, 32'h0, 4'h0, 16'h0000, 1'b0};
        tv[3] = '{11'h7FF, 8, 0, -1, 2, 11'h7FF, 32'h44332211, 4'hF, 11'h000, 32'h88776655, 4'hF, 16'h0264, 1'b1};
        tv[4] = '{11'h020, 1, 0, -1, 1, 11'h020, 32'h00000011, 4'h1, 11'h020, 32'h00000011, 4'h1, 16'h0011, 1'b0};
        tv[5] = '{11'h7FE, 5, 30, -1, 2, 11'h7FE, 32'h44332211, 4'hF, 11'h7FF, 32'h00000055, 4'h1, 16'h00FF, 1'b1};
        tv[6] = '{11'h010, 8, 50, 3, 2, 11'h010, 32'h44332211, 4'hF, 11'h011, 32'h88776655, 4'hF, 16'h0264, 1'b0};
        for (int i = 0; i < 16; i++) bytes[i] = 8'(8'h11 * (i + 1));

        // Reset held with live inputs: everything quiet
        in_valid = 1'b1; start = 1'b1; byte_count = 13'd8; in_data = 8'hAB;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("rst_ctrl", {in_ready, mem_address, mem_byteenable, mem_chipselect, mem_write,
                         busy, done, checksum, wrapped}, 0);
        chk("rst_wdata", mem_writedata, 0);
        chk("rst_no_write", obs.size(), 0);
        @(posedge clk); #1;
        start = 1'b0; in_valid = 1'b0; reset_n = 1'b1;
        repeat (2) @(posedge clk);

        for (int t = 0; t < 7; t++) begin
            run_load(tv[t].sa, tv[t].cnt, tv[t].gap, tv[t].inject);
            check_model(tv[t].sa, tv[t].cnt);
            chk("tv_nw", obs.size(), tv[t].nw);
            if (tv[t].nw > 0 && obs.size() > 0) begin
                chk("tv_a0", obs[0].a, tv[t].a0);
                chk("tv_d0", obs[0].d, tv[t].d0);
                chk("tv_b0", obs[0].be, tv[t].b0);
                chk("tv_al", obs[obs.size() - 1].a, tv[t].al);
                chk("tv_dl", obs[obs.size() - 1].d, tv[t].dl);
                chk("tv_bl", obs[obs.size() - 1].be, tv[t].bl);
            end
            chk("tv_cks", checksum, tv[t].cks);
            chk("tv_wrap", wrapped, tv[t].wrap);
        end

        // Abort after two bytes: the partial word must never reach the RAM
        clear_obs();
        @(posedge clk); #1;
        start = 1'b1; start_addr = 11'h010; byte_count = 13'd8;
        @(posedge clk); #1;
        start = 1'b0; in_valid = 1'b1; in_data = bytes[0];
        @(posedge clk); #1;
        in_data = bytes[1];
        @(posedge clk); #1;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_ready", in_ready, 0);
        chk("abort_cks", checksum, 0);
        @(posedge clk); #1;
        reset_n = 1'b1; in_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("abort_no_write", obs.size(), 0);
        run_load(11'h010, 8, 0, -1);
        check_model(11'h010, 8);

        // Randomized loads against the reference model
        for (int r = 0; r < 25; r++) begin
            logic [10:0] sa;
            int          cnt;
            int          inj;
            sa  = ($urandom_range(3) == 0) ? 11'(2048 - $urandom_range(1, 3)) : 11'($urandom);
            cnt = $urandom_range(0, 14);
            inj = ($urandom_range(3) == 0) ? $urandom_range(0, 14) : -1;
            for (int i = 0; i < 16; i++) bytes[i] = 8'($urandom);
            run_load(sa, cnt, $urandom_range(0, 60), inj);
            check_model(sa, cnt);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
